// File: rtl/core_regfile_mp_pkg.sv
// Shared types for the multi-port register file: clear-engine state encoding.
package core_regfile_mp_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/core_regfile_mp_rdport.sv
// One read port: stored-value select, same-cycle write bypass and busy masking.
module core_regfile_mp_rdport
    import core_regfile_mp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]      raddr_i,
    input  logic [NWR-1:0]         we_i,
    input  logic [NWR*ADDR_W-1:0]  waddr_i,
    input  logic [NWR*XLEN-1:0]    wdata_i,
    input  logic                   ready_i,
    input  logic [NREGS*XLEN-1:0]  regs_i,
    input  logic [NREGS-1:0]       sb_i,
    output logic [XLEN-1:0]        rdata_o,
    output logic                   busy_o
);

    logic            hit;
    logic [XLEN-1:0] byp_data;
    logic            use_byp;
    logic [XLEN-1:0] stored;

    // Find the highest-index enabled write port aimed at this read address.
    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        for (int p = 0; p < NWR; p++) begin
            if (ready_i && we_i[p] && (waddr_i[p*ADDR_W +: ADDR_W] == raddr_i)) begin
                hit      = 1'b1;
                byp_data = wdata_i[p*XLEN +: XLEN];
            end
        end
    end

    // Select bypass or stored data; a bypass hit also satisfies a pending producer.
    always_comb begin
        use_byp = (BYPASS != 0) && hit;
        stored  = regs_i[int'(raddr_i)*XLEN +: XLEN];
        if (raddr_i == '0) begin
            rdata_o = '0;
            busy_o  = 1'b0;
        end else begin
            rdata_o = use_byp ? byp_data : stored;
            busy_o  = sb_i[raddr_i] & ~use_byp;
        end
    end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and a
// sequenced bulk-clear engine that zeroes one register per cycle.
module core_regfile_mp
    import core_regfile_mp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         we_in,
    input  logic [NWR*ADDR_W-1:0]  waddr_in,
    input  logic [NWR*XLEN-1:0]    wdata_in,
    input  logic [NRD*ADDR_W-1:0]  raddr_in,
    output logic [NRD*XLEN-1:0]    rdata_out,
    input  logic                   busy_set_in,
    input  logic [ADDR_W-1:0]      busy_addr_in,
    output logic [NRD-1:0]         busy_out,
    input  logic                   clr_req_in,
    output logic                   ready_out
);

    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NREGS - 1);

    rf_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      sb_q, sb_d;
    logic [NREGS*XLEN-1:0] regs_flat;

    // Clear-engine state and sweep counter; counter parks at 1 so a new sweep starts at reg 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= FIRST_REG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep regs 1..NREGS-1 once per clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                cnt_d = FIRST_REG;
                if (clr_req_in) state_d = RF_CLEAR;
            end
            RF_CLEAR: begin
                if (cnt_q == LAST_REG) begin
                    state_d = RF_IDLE;
                    cnt_d   = FIRST_REG;
                end else begin
                    cnt_d = cnt_q + FIRST_REG;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = FIRST_REG;
            end
        endcase
    end

    // Writes and busy marks are only accepted while the engine is idle.
    always_comb begin
        ready_out = (state_q == RF_IDLE);
    end

    // Next array/scoreboard contents: later write ports override earlier ones,
    // and a busy mark applied last so a newly issued producer beats a retiring one.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (state_q == RF_IDLE) begin
            for (int p = 0; p < NWR; p++) begin
                if (we_in[p] && (waddr_in[p*ADDR_W +: ADDR_W] != '0)) begin
                    regs_d[waddr_in[p*ADDR_W +: ADDR_W]] = wdata_in[p*XLEN +: XLEN];
                    sb_d[waddr_in[p*ADDR_W +: ADDR_W]]   = 1'b0;
                end
            end
            if (busy_set_in && (busy_addr_in != '0)) begin
                sb_d[busy_addr_in] = 1'b1;
            end
        end else begin
            regs_d[cnt_q] = '0;
            sb_d[cnt_q]   = 1'b0;
        end
        regs_d[0] = '0;
        sb_d[0]   = 1'b0;
    end

    // Register array and scoreboard storage; every entry resets so reads never see X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NREGS; a++) begin
                regs_q[a] <= '0;
            end
            sb_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    for (genvar a = 0; a < NREGS; a++) begin : g_flat
        assign regs_flat[a*XLEN +: XLEN] = regs_q[a];
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        core_regfile_mp_rdport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .ADDR_W (ADDR_W),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rdport (
            .raddr_i (raddr_in[i*ADDR_W +: ADDR_W]),
            .we_i    (we_in),
            .waddr_i (waddr_in),
            .wdata_i (wdata_in),
            .ready_i (ready_out),
            .regs_i  (regs_flat),
            .sb_i    (sb_q),
            .rdata_o (rdata_out[i*XLEN +: XLEN]),
            .busy_o  (busy_out[i])
        );
    end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Bench for core_regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_core_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic        clr_req;
    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  busy_b, busy_n;
    logic        ready_b, ready_n;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] obs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    core_regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we_in(we), .waddr_in(waddr), .wdata_in(wdata),
        .raddr_in(raddr), .rdata_out(rdata_b), .busy_set_in(busy_set),
        .busy_addr_in(busy_addr), .busy_out(busy_b), .clr_req_in(clr_req),
        .ready_out(ready_b)
    );

    core_regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we_in(we), .waddr_in(waddr), .wdata_in(wdata),
        .raddr_in(raddr), .rdata_out(rdata_n), .busy_set_in(busy_set),
        .busy_addr_in(busy_addr), .busy_out(busy_n), .clr_req_in(clr_req),
        .ready_out(ready_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we = '0; waddr = '0; wdata = '0;
        busy_set = 1'b0; busy_addr = '0; clr_req = 1'b0;
    endtask

    task automatic push(input string n, input logic [31:0] v);
        exp_t x;
        x.name = n;
        x.val  = v;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        idle_in();
        raddr = '0;
        #2 rst = 1'b1;
        #1;
        push("reset_ready", 32'd1);
        e = exp_q.pop_front(); obs = {31'b0, ready_b}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        for (int a = 1; a < 32; a++) begin
            raddr = {5'(32 - a), 5'(a)};
            #1;
            push("reset_rdata_p0", 32'h0);
            push("reset_rdata_p1", 32'h0);
            push("reset_busy", 32'h0);
            e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s a=%0d: got %h expected %h", e.name, a, obs, e.val); end
            e = exp_q.pop_front(); obs = rdata_n[63:32]; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s a=%0d: got %h expected %h", e.name, a, obs, e.val); end
            e = exp_q.pop_front(); obs = {30'b0, busy_b}; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s a=%0d: got %h expected %h", e.name, a, obs, e.val); end
        end
        @(negedge clk) rst = 1'b0;
        step();
    endtask

    task automatic test_write_priority();
        we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h5555_0002, 32'hAAAA_0001};
        raddr = {5'd5, 5'd5};
        #1;
        push("wprio_bypass_same_cycle", 32'h5555_0002);
        push("wprio_nobypass_same_cycle", 32'h0);
        e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        step(); idle_in(); #1;
        push("wprio_stored_b", 32'h5555_0002);
        push("wprio_stored_n", 32'h5555_0002);
        e = exp_q.pop_front(); obs = rdata_b[63:32]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_bypass();
        we = 2'b11; waddr = {5'd0, 5'd7}; wdata = {32'hFFFF_FFFF, 32'h0000_1234};
        raddr = {5'd0, 5'd7};
        #1;
        push("bypass_r7_b", 32'h1234);
        push("bypass_r7_n_old", 32'h0);
        push("bypass_r0_write", 32'h0);
        e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_b[63:32]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        step(); idle_in(); #1;
        push("bypass_r7_n_next", 32'h1234);
        push("r0_after_write", 32'h0);
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[63:32]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_scoreboard();
        busy_set = 1'b1; busy_addr = 5'd9; raddr = {5'd0, 5'd9};
        step(); idle_in(); #1;
        push("sb_set_b", 32'd1);
        push("sb_set_n", 32'd1);
        e = exp_q.pop_front(); obs = {31'b0, busy_b[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_n[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        #1;
        push("sb_bypass_mask_b", 32'd0);
        push("sb_no_mask_n", 32'd1);
        e = exp_q.pop_front(); obs = {31'b0, busy_b[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_n[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        step(); idle_in(); #1;
        push("sb_cleared_by_write", 32'd0);
        e = exp_q.pop_front(); obs = {31'b0, busy_n[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        busy_set = 1'b1; busy_addr = 5'd9;
        we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h77, 32'h0};
        step(); idle_in(); #1;
        push("sb_set_beats_clear_b", 32'd1);
        push("sb_set_beats_clear_n", 32'd1);
        push("sb_set_write_data", 32'h77);
        e = exp_q.pop_front(); obs = {31'b0, busy_b[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_n[0]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_clear();
        int lowcnt;
        for (int k = 0; k < 16; k++) begin
            we = 2'b11;
            waddr = {5'(2*k + 2), 5'(2*k + 1)};
            wdata = {32'hFF, 32'hFF};
            step();
        end
        idle_in();
        busy_set = 1'b1; busy_addr = 5'd3;
        step(); idle_in();
        raddr = {5'd31, 5'd1};
        #1;
        push("fill_r1", 32'hFF);
        push("fill_r31", 32'hFF);
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[63:32]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        lowcnt = 0;
        while (ready_b === 1'b0 && lowcnt < 100) begin
            lowcnt++;
            if (lowcnt == 6) begin
                raddr = {5'd4, 5'd6};
                we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hABCD};
                busy_set = 1'b1; busy_addr = 5'd2;
                #1;
                push("mid_clear_r6_not_yet", 32'hFF);
                push("mid_clear_no_bypass", 32'h0);
                e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
                e = exp_q.pop_front(); obs = rdata_b[63:32]; checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            step();
            idle_in();
        end
        push("clear_busy_cycles", 32'd31);
        e = exp_q.pop_front(); obs = 32'(lowcnt); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
        for (int a = 1; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            push("cleared_rdata", 32'h0);
            push("cleared_busy", 32'h0);
            e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s r%0d: got %h expected %h", e.name, a, obs, e.val); end
            e = exp_q.pop_front(); obs = {30'b0, busy_n}; checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s r%0d: got %h expected %h", e.name, a, obs, e.val); end
        end
    endtask

    task automatic test_clear_held();
        int lowcnt;
        clr_req = 1'b1;
        step();
        lowcnt = 0;
        while (ready_b === 1'b0 && lowcnt < 100) begin
            lowcnt++;
            step();
        end
        push("held_first_sweep", 32'd31);
        push("held_idle_gap_ready", 32'd1);
        e = exp_q.pop_front(); obs = 32'(lowcnt); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, ready_n}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        step();
        push("held_restart", 32'd0);
        e = exp_q.pop_front(); obs = {31'b0, ready_b}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        clr_req = 1'b0;
        lowcnt = 0;
        while (ready_b === 1'b0 && lowcnt < 100) begin
            lowcnt++;
            step();
        end
        push("held_second_sweep_end", 32'd1);
        e = exp_q.pop_front(); obs = {31'b0, ready_b}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_rst_mid_clear();
        we = 2'b11; waddr = {5'd30, 5'd20}; wdata = {32'hBEEF, 32'hDEAD};
        busy_set = 1'b1; busy_addr = 5'd25;
        step(); idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        raddr = {5'd25, 5'd20};
        #1;
        push("pre_rst_r20", 32'hDEAD);
        push("pre_rst_busy25", 32'd1);
        e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_b[1]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        rst = 1'b1;
        #1;
        push("rst_mid_ready", 32'd1);
        push("rst_mid_r20", 32'h0);
        push("rst_mid_busy25", 32'd0);
        e = exp_q.pop_front(); obs = {31'b0, ready_b}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = rdata_n[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_b[1]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        raddr = {5'd25, 5'd30};
        #1;
        push("rst_mid_r30", 32'h0);
        e = exp_q.pop_front(); obs = rdata_b[31:0]; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        @(negedge clk) rst = 1'b0;
        step();
        push("post_rst_ready", 32'd1);
        push("post_rst_busy25", 32'd0);
        e = exp_q.pop_front(); obs = {31'b0, ready_b}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        e = exp_q.pop_front(); obs = {31'b0, busy_n[1]}; checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    initial begin
        idle_in();
        raddr = '0;
        test_reset();
        test_write_priority();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_clear_held();
        test_rst_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
